// File: rtl/rs232_rx_ctrl.sv
// RS232 receive controller: oversampled framing of one byte per frame with optional
// parity, held for the Nios behind a ready / read-ack level handshake.
module rs232_rx_ctrl #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       rx_serial,
    input  logic [7:0] rx_options,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ack,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DIV_9600   = CLK_HZ / (9600 * OVERSAMPLE);
    localparam int unsigned DIV_19200  = CLK_HZ / (19200 * OVERSAMPLE);
    localparam int unsigned DIV_57600  = CLK_HZ / (57600 * OVERSAMPLE);
    localparam int unsigned DIV_115200 = CLK_HZ / (115200 * OVERSAMPLE);

    // The slowest baud has the largest divisor and sets the counter width
    localparam int unsigned TICK_W = (DIV_9600 > 2) ? $clog2(DIV_9600) : 1;
    localparam int unsigned OS_W   = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] LAST_9600   = TICK_W'(DIV_9600 - 1);
    localparam logic [TICK_W-1:0] LAST_19200  = TICK_W'(DIV_19200 - 1);
    localparam logic [TICK_W-1:0] LAST_57600  = TICK_W'(DIV_57600 - 1);
    localparam logic [TICK_W-1:0] LAST_115200 = TICK_W'(DIV_115200 - 1);

    localparam logic [OS_W-1:0] OS_FULL_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } state_e;

    state_e              r_state;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [TICK_W-1:0]   r_tick_last;
    logic [OS_W-1:0]     r_os_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_par_en;
    logic                r_par_odd;
    logic                r_par_err;
    logic                r_frm_err;

    logic r_rx_meta, r_rx_sync, r_rx_prev;
    logic r_ack_meta, r_ack_sync, r_ack_prev;

    logic [TICK_W-1:0] w_last_sel;
    logic              w_tick;
    logic              w_fall;
    logic              w_ack_edge;
    logic              w_unused_opts;

    assign w_unused_opts = ^rx_options[7:4];

    // Synchronize the line and the ack level; preset high so reset never looks like an edge
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_ack_meta <= 1'b1;
            r_ack_sync <= 1'b1;
            r_ack_prev <= 1'b1;
        end else begin
            r_rx_meta  <= rx_serial;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_ack_meta <= rx_ack;
            r_ack_sync <= r_ack_meta;
            r_ack_prev <= r_ack_sync;
        end
    end

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    assign w_ack_edge = r_ack_sync & ~r_ack_prev;
    assign w_tick     = (r_tick_cnt == r_tick_last);

    // Divisor terminal count for the currently requested baud
    always_comb begin
        w_last_sel = LAST_9600;
        case (rx_options[1:0])
            2'b00:   w_last_sel = LAST_9600;
            2'b01:   w_last_sel = LAST_19200;
            2'b10:   w_last_sel = LAST_57600;
            default: w_last_sel = LAST_115200;
        endcase
    end

    // Frame FSM, tick counter and the held byte with its handshake flags
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state     <= StIdle;
            r_tick_cnt  <= '0;
            r_tick_last <= '0;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            rx_data     <= '0;
            rx_ready    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // Ack is applied first so a commit in the same cycle sees an empty holding slot
            if (w_ack_edge) begin
                rx_ready   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end

            if (r_state == StIdle || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            case (r_state)
                StIdle: begin
                    if (w_fall) begin
                        r_state     <= StStart;
                        r_os_cnt    <= '0;
                        r_bit_cnt   <= '0;
                        r_tick_last <= w_last_sel;
                        r_par_en    <= rx_options[2];
                        r_par_odd   <= rx_options[3];
                        r_par_err   <= 1'b0;
                        r_frm_err   <= 1'b0;
                    end
                end
                StStart: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_HALF_LAST) begin
                            r_os_cnt <= '0;
                            r_state  <= r_rx_sync ? StIdle : StData;
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_FULL_LAST) begin
                            r_os_cnt  <= '0;
                            r_shift   <= {r_rx_sync, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= r_par_en ? StParity : StStop;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_FULL_LAST) begin
                            r_os_cnt  <= '0;
                            r_par_err <= (^r_shift) ^ r_rx_sync ^ r_par_odd;
                            r_state   <= StStop;
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_FULL_LAST) begin
                            r_os_cnt  <= '0;
                            r_frm_err <= ~r_rx_sync;
                            r_state   <= StDone;
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    if (!rx_ready || w_ack_edge) begin
                        rx_data    <= r_shift;
                        parity_err <= r_par_err;
                        frame_err  <= r_frm_err;
                        rx_ready   <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// Self-checking bench for rs232_rx_ctrl at the default 50 MHz clock.
module tb_rs232_rx_ctrl;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       rx_serial;
    logic [7:0] rx_options;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    typedef struct {
        logic [7:0] opts;
        logic [7:0] data;
        logic       par_bit;
        logic       stop_bit;
        int         bit_clk;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[4];

    rs232_rx_ctrl dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .rx_serial   (rx_serial),
        .rx_options  (rx_options),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_ack      (rx_ack),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #10 clk_clk = ~clk_clk;

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " rx_data"}, 32'(rx_data), 32'h0);
        check({name, " rx_ready"}, 32'(rx_ready), 32'h0);
        check({name, " parity_err"}, 32'(parity_err), 32'h0);
        check({name, " frame_err"}, 32'(frame_err), 32'h0);
        check({name, " overrun"}, 32'(overrun), 32'h0);
    endtask

    // Drive one frame; the stop bit is cut after 3/4 of a bit, well past its sample point
    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input logic stop_bit, input int bit_clk);
        rx_serial = 1'b0;
        repeat (bit_clk) @(negedge clk_clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            repeat (bit_clk) @(negedge clk_clk);
        end
        if (par_en) begin
            rx_serial = par_bit;
            repeat (bit_clk) @(negedge clk_clk);
        end
        rx_serial = stop_bit;
        repeat (bit_clk * 3 / 4) @(negedge clk_clk);
        rx_serial = 1'b1;
        repeat (16) @(negedge clk_clk);
    endtask

    // Wait (bounded) for rx_ready, then compare against the oldest scoreboard entry
    task automatic expect_byte(input string name);
        exp_t e;
        for (int c = 0; c < 2000 && !rx_ready; c++) @(negedge clk_clk);
        check({name, " rx_ready"}, 32'(rx_ready), 32'h1);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, want an entry", name);
        end else begin
            e = sb_q.pop_front();
            check({name, " rx_data"}, 32'(rx_data), 32'(e.data));
            check({name, " parity_err"}, 32'(parity_err), 32'(e.perr));
            check({name, " frame_err"}, 32'(frame_err), 32'(e.ferr));
            check({name, " overrun"}, 32'(overrun), 32'(e.ovr));
        end
    endtask

    task automatic do_ack(input string name, input logic [7:0] held);
        rx_ack = 1'b1;
        repeat (4) @(negedge clk_clk);
        check({name, " ack rx_ready"}, 32'(rx_ready), 32'h0);
        check({name, " ack rx_data kept"}, 32'(rx_data), 32'(held));
        check({name, " ack parity_err"}, 32'(parity_err), 32'h0);
        check({name, " ack frame_err"}, 32'(frame_err), 32'h0);
        check({name, " ack overrun"}, 32'(overrun), 32'h0);
        rx_ack = 1'b0;
        repeat (4) @(negedge clk_clk);
    endtask

    initial begin
        // opts, data, parity bit, stop bit, bit length in clk, parity_err, frame_err
        vecs[0] = '{8'h03, 8'hA5, 1'b0, 1'b1, 432, 1'b0, 1'b0};
        vecs[1] = '{8'h0F, 8'h3C, 1'b1, 1'b1, 432, 1'b0, 1'b0};
        vecs[2] = '{8'h0F, 8'h3C, 1'b0, 1'b1, 432, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 8'h5A, 1'b0, 1'b0, 5200, 1'b0, 1'b1};

        reset_reset = 1'b1;
        rx_serial   = 1'b1;
        rx_ack      = 1'b0;
        rx_options  = 8'h03;
        repeat (5) @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (4) @(negedge clk_clk);
        check_idle_outputs("reset");

        foreach (vecs[i]) begin
            rx_options = vecs[i].opts;
            sb_q.push_back(exp_t'{vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr, 1'b0});
            send_frame(vecs[i].data, vecs[i].opts[2], vecs[i].par_bit, vecs[i].stop_bit,
                       vecs[i].bit_clk);
            expect_byte($sformatf("vec%0d", i));
            do_ack($sformatf("vec%0d", i), vecs[i].data);
        end

        // Overrun: second byte arrives while the first is still held
        rx_options = 8'h03;
        sb_q.push_back(exp_t'{8'h11, 1'b0, 1'b0, 1'b0});
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 432);
        expect_byte("ovr first");
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 432);
        check("ovr held data", 32'(rx_data), 32'h11);
        check("ovr flag", 32'(overrun), 32'h1);
        check("ovr still ready", 32'(rx_ready), 32'h1);
        do_ack("ovr", 8'h11);
        sb_q.push_back(exp_t'{8'h33, 1'b0, 1'b0, 1'b0});
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 432);
        expect_byte("ovr after ack");

        // Ack edge lands in the DONE cycle of 0x55 while 0x33 is held: stop sample at clk 4107
        // after the start edge, so the ack must reach the synchronizer before clk 4106
        fork
            send_frame(8'h55, 1'b0, 1'b0, 1'b1, 432);
            begin
                repeat (4105) @(negedge clk_clk);
                rx_ack = 1'b1;
            end
        join
        check("align rx_data", 32'(rx_data), 32'h55);
        check("align rx_ready", 32'(rx_ready), 32'h1);
        check("align overrun", 32'(overrun), 32'h0);
        rx_ack = 1'b0;
        repeat (4) @(negedge clk_clk);
        do_ack("align", 8'h55);

        // False start: 100 clk low pulse is high again at the half-bit sample
        rx_serial = 1'b0;
        repeat (100) @(negedge clk_clk);
        rx_serial = 1'b1;
        repeat (400) @(negedge clk_clk);
        check("false start rx_ready", 32'(rx_ready), 32'h0);
        check("false start overrun", 32'(overrun), 32'h0);
        sb_q.push_back(exp_t'{8'h7E, 1'b0, 1'b0, 1'b0});
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 432);
        expect_byte("after false start");
        do_ack("after false start", 8'h7E);

        // Reset in the middle of the data bits of 0x81 discards the partial frame
        rx_serial = 1'b0;
        repeat (432) @(negedge clk_clk);
        rx_serial = 1'b1;
        repeat (432) @(negedge clk_clk);
        rx_serial = 1'b0;
        repeat (632) @(negedge clk_clk);
        reset_reset = 1'b1;
        rx_serial   = 1'b1;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (8) @(negedge clk_clk);
        check_idle_outputs("mid-frame reset");
        sb_q.push_back(exp_t'{8'h42, 1'b0, 1'b0, 1'b0});
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, 432);
        expect_byte("after reset");
        repeat (200) @(negedge clk_clk);
        check("no extra byte", 32'(rx_data), 32'h42);
        check("scoreboard drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
